// File: rtl/seq_pkg.sv
// Shared definitions for the stage sequencer: phase codes, default masks and
// the previous-viewable-stage search used when stepping backwards.
package seq_pkg;

    typedef enum logic [2:0] {
        PH_VIEW  = 3'd0,
        PH_START = 3'd1,
        PH_WAIT  = 3'd2,
        PH_SHOW  = 3'd3,
        PH_ERROR = 3'd4
    } phase_t;

    localparam int         DEF_NUM_STAGES = 8;
    localparam logic [7:0] DEF_SHOW_MASK  = 8'b0000_0111;
    localparam logic [7:0] DEF_DELAY_MASK = 8'b0100_0000;

    // Returns {found, index} of the highest j < cur with mask[j] set.
    function automatic logic [4:0] prev_show(input logic [15:0] mask, input logic [3:0] cur);
        logic [4:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < int'(cur) && mask[j]) begin
                r = {1'b1, 4'(j)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_cycle_timer.sv
// Loadable down-counter shared by fixed-delay stages and the WAIT timeout.
// Saturates at zero; zero flag is combinational from the count.
module seq_cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Parametrised pipeline stage sequencer: start/done handshake per stage, SHOW
// pauses, fixed-delay stages. Optional WAIT timeout under SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// PH_VIEW  | idle on the source image, waiting for a forward press
// PH_START | one cycle, start pulse for the active stage, timer loads
// PH_WAIT  | waiting for done (or delay expiry) of the active stage
// PH_SHOW  | paused for viewing; fwd/skip advance, back rewinds
// PH_ERROR | active stage timed out (SEQ_TIMEOUT_EN only)
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int                    NUM_STAGES     = DEF_NUM_STAGES,
    parameter int                    STAGE_W        = 4,
    parameter logic [NUM_STAGES-1:0] SHOW_MASK      = DEF_SHOW_MASK,
    parameter logic [NUM_STAGES-1:0] DELAY_MASK     = DEF_DELAY_MASK,
    parameter int                    DELAY_CYCLES   = 100,
    parameter int                    CNT_W          = 16,
    parameter int                    TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button_enter,
    input  logic                  switch,
    input  logic                  skip,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [STAGE_W-1:0]    stage,
    output logic [2:0]            phase,
    output logic                  busy,
    output logic                  error
);

    localparam logic [STAGE_W-1:0] LAST      = STAGE_W'(NUM_STAGES - 1);
    localparam logic [15:0]        SHOW_PAD  = 16'(SHOW_MASK);
    localparam logic [15:0]        DELAY_PAD = 16'(DELAY_MASK);

    phase_t           state;
    logic             last_enter;
    logic             press, fwd, back, adv;
    logic [3:0]       idx;
    logic [15:0]      done_pad;
    logic             is_delay, complete, cnt_zero;
    logic [CNT_W-1:0] load_value;
    logic [4:0]       prev;

    function automatic logic [NUM_STAGES-1:0] one_hot(input logic [STAGE_W-1:0] s);
        return {{(NUM_STAGES-1){1'b0}}, 1'b1} << s;
    endfunction

    assign press    = button_enter & ~last_enter;
    assign fwd      = press & switch;
    assign back     = press & ~switch;
    assign adv      = fwd | skip;
    assign idx      = 4'(stage);
    assign done_pad = 16'(stage_done);
    assign is_delay = DELAY_PAD[idx];
    assign complete = is_delay ? cnt_zero : done_pad[idx];
    assign prev     = prev_show(SHOW_PAD, idx);
    assign phase    = state;

    // Timeout loads one short so the error lands after exactly TIMEOUT_CYCLES of WAIT.
    assign load_value = is_delay ? CNT_W'(DELAY_CYCLES) : CNT_W'(TIMEOUT_CYCLES - 1);

    seq_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state == PH_START),
        .value (load_value),
        .dec   (state == PH_WAIT),
        .zero  (cnt_zero)
    );

`ifdef SEQ_TIMEOUT_EN
    logic error_r;
    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PH_VIEW;
            stage       <= '0;
            stage_start <= '0;
            busy        <= 1'b0;
            last_enter  <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            error_r     <= 1'b0;
`endif
        end else begin
            last_enter  <= button_enter;
            stage_start <= '0;
            case (state)
                PH_VIEW: begin
                    if (fwd) begin
                        state       <= PH_START;
                        stage       <= '0;
                        stage_start <= one_hot('0);
                        busy        <= 1'b1;
                    end
                end
                PH_START: begin
                    state <= PH_WAIT;
                end
                PH_WAIT: begin
                    if (complete) begin
                        if (SHOW_PAD[idx] || stage == LAST) begin
                            state <= PH_SHOW;
                            busy  <= 1'b0;
                        end else begin
                            state       <= PH_START;
                            stage       <= stage + 1'b1;
                            stage_start <= one_hot(stage + 1'b1);
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (!is_delay && cnt_zero) begin
                        state   <= PH_ERROR;
                        busy    <= 1'b0;
                        error_r <= 1'b1;
                    end
`endif
                end
                PH_SHOW: begin
                    if (adv && stage != LAST) begin
                        state       <= PH_START;
                        stage       <= stage + 1'b1;
                        stage_start <= one_hot(stage + 1'b1);
                        busy        <= 1'b1;
                    end else if (back) begin
                        if (prev[4]) begin
                            state       <= PH_START;
                            stage       <= STAGE_W'(prev[3:0]);
                            stage_start <= one_hot(STAGE_W'(prev[3:0]));
                            busy        <= 1'b1;
                        end else begin
                            state <= PH_VIEW;
                            stage <= '0;
                        end
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                PH_ERROR: begin
                    if (back) begin
                        state   <= PH_VIEW;
                        stage   <= '0;
                        error_r <= 1'b0;
                    end else if (fwd) begin
                        state       <= PH_START;
                        stage_start <= one_hot(stage);
                        busy        <= 1'b1;
                        error_r     <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= PH_VIEW;
                    stage <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: 4 stages, stages 0 and 2 viewable,
// stage 2 on a 5-cycle fixed delay. Timeout scenario under SEQ_TIMEOUT_EN.
module tb_stage_sequencer;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button_enter = 1'b1;
    logic       switch = 1'b1;
    logic       skip = 1'b0;
    logic [3:0] stage_done = 4'b0000;
    logic [3:0] stage_start;
    logic [1:0] stage;
    logic [2:0] phase;
    logic       busy;
    logic       error;

    int n_cmp = 0;
    int n_bad = 0;

    stage_sequencer #(
        .NUM_STAGES     (4),
        .STAGE_W        (2),
        .SHOW_MASK      (4'b0101),
        .DELAY_MASK     (4'b0100),
        .DELAY_CYCLES   (5),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_enter (button_enter),
        .switch       (switch),
        .skip         (skip),
        .stage_done   (stage_done),
        .stage_start  (stage_start),
        .stage        (stage),
        .phase        (phase),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; button_enter = 1'b1; switch = 1'b1;
        step(); step();
        n_cmp++; if (phase !== PH_VIEW) begin n_bad++; $display("FAIL reset_phase: got %0d want %0d", phase, PH_VIEW); end
        n_cmp++; if (stage !== 2'd0) begin n_bad++; $display("FAIL reset_stage: got %0d want 0", stage); end
        n_cmp++; if (stage_start !== 4'b0000) begin n_bad++; $display("FAIL reset_start: got %b want 0000", stage_start); end
        n_cmp++; if ({busy, error} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_err: got %b want 00", {busy, error}); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (phase !== PH_VIEW || stage_start !== 4'b0000) begin
                n_bad++; $display("FAIL held_button: phase %0d start %b want 0 / 0000", phase, stage_start);
            end
        end
    endtask

    task automatic test_press_and_ignore();
        button_enter = 1'b0; step();
        button_enter = 1'b1; step();
        n_cmp++; if (stage_start !== 4'b0001) begin n_bad++; $display("FAIL press_start: got %b want 0001", stage_start); end
        n_cmp++; if (phase !== PH_START || busy !== 1'b1) begin n_bad++; $display("FAIL press_phase: got %0d/%b want 1/1", phase, busy); end
        // done[0] during START only, then a foreign done during WAIT
        button_enter = 1'b0; stage_done = 4'b0001; step();
        n_cmp++; if (phase !== PH_WAIT || stage_start !== 4'b0000) begin
            n_bad++; $display("FAIL start_one_cycle: phase %0d start %b want 2 / 0000", phase, stage_start);
        end
        stage_done = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (phase !== PH_WAIT || stage !== 2'd0) begin
                n_bad++; $display("FAIL foreign_done: phase %0d stage %0d want 2 / 0", phase, stage);
            end
        end
        stage_done = 4'b0001; step();
        n_cmp++; if (phase !== PH_SHOW || stage !== 2'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL done0_show: phase %0d stage %0d busy %b want 3 / 0 / 0", phase, stage, busy);
        end
        stage_done = 4'b0000;
    endtask

    task automatic test_autochain();
        int w;
        // fwd and skip together advance a single stage
        skip = 1'b1; button_enter = 1'b1; switch = 1'b1; step();
        n_cmp++; if (stage_start !== 4'b0010 || stage !== 2'd1) begin
            n_bad++; $display("FAIL skip_start1: start %b stage %0d want 0010 / 1", stage_start, stage);
        end
        skip = 1'b0; button_enter = 1'b0; step();
        n_cmp++; if (phase !== PH_WAIT || stage !== 2'd1) begin n_bad++; $display("FAIL single_advance: phase %0d stage %0d want 2 / 1", phase, stage); end
        step();
        stage_done = 4'b0010;
        n_cmp++; if (stage_start !== 4'b0000) begin n_bad++; $display("FAIL no_early_start: got %b want 0000", stage_start); end
        step();
        n_cmp++; if (phase !== PH_START || stage !== 2'd2 || stage_start !== 4'b0100) begin
            n_bad++; $display("FAIL chain_start2: phase %0d stage %0d start %b want 1 / 2 / 0100", phase, stage, stage_start);
        end
        // stage 2 is a delay stage: done held high must not shorten it
        stage_done = 4'b0100;
        step();
        w = 0;
        for (int i = 0; i < 20 && phase == PH_WAIT; i++) begin w++; step(); end
        n_cmp++; if (w !== 6) begin n_bad++; $display("FAIL delay_wait_len: got %0d want 6", w); end
        n_cmp++; if (phase !== PH_SHOW || stage !== 2'd2) begin n_bad++; $display("FAIL delay_show: phase %0d stage %0d want 3 / 2", phase, stage); end
        stage_done = 4'b0000;
        skip = 1'b1; step();
        n_cmp++; if (stage_start !== 4'b1000 || stage !== 2'd3) begin n_bad++; $display("FAIL skip_start3: start %b stage %0d want 1000 / 3", stage_start, stage); end
        skip = 1'b0; step();
        stage_done = 4'b1000; step();
        n_cmp++; if (phase !== PH_SHOW || stage !== 2'd3 || busy !== 1'b0) begin
            n_bad++; $display("FAIL last_show: phase %0d stage %0d busy %b want 3 / 3 / 0", phase, stage, busy);
        end
        stage_done = 4'b0000;
        button_enter = 1'b1; switch = 1'b1; step();
        n_cmp++; if (phase !== PH_SHOW || stage !== 2'd3 || stage_start !== 4'b0000) begin
            n_bad++; $display("FAIL last_fwd: phase %0d stage %0d start %b want 3 / 3 / 0000", phase, stage, stage_start);
        end
        button_enter = 1'b0; skip = 1'b1; step();
        n_cmp++; if (phase !== PH_SHOW || stage !== 2'd3) begin n_bad++; $display("FAIL last_skip: phase %0d stage %0d want 3 / 3", phase, stage); end
        skip = 1'b0; step();
    endtask

    task automatic test_back();
        button_enter = 1'b1; switch = 1'b0; step();
        n_cmp++; if (stage_start !== 4'b0100 || stage !== 2'd2) begin n_bad++; $display("FAIL back_to2: start %b stage %0d want 0100 / 2", stage_start, stage); end
        button_enter = 1'b0;
        for (int i = 0; i < 20 && phase != PH_SHOW; i++) step();
        n_cmp++; if (phase !== PH_SHOW || stage !== 2'd2) begin n_bad++; $display("FAIL back_show2: phase %0d stage %0d want 3 / 2", phase, stage); end
        button_enter = 1'b1; step();
        n_cmp++; if (stage_start !== 4'b0001 || stage !== 2'd0) begin n_bad++; $display("FAIL back_to0: start %b stage %0d want 0001 / 0", stage_start, stage); end
        button_enter = 1'b0; step();
        stage_done = 4'b0001; step();
        stage_done = 4'b0000;
        n_cmp++; if (phase !== PH_SHOW || stage !== 2'd0) begin n_bad++; $display("FAIL back_show0: phase %0d stage %0d want 3 / 0", phase, stage); end
        button_enter = 1'b1; step();
        n_cmp++; if (phase !== PH_VIEW || stage !== 2'd0 || stage_start !== 4'b0000) begin
            n_bad++; $display("FAIL back_view: phase %0d stage %0d start %b want 0 / 0 / 0000", phase, stage, stage_start);
        end
        button_enter = 1'b0; switch = 1'b1; step();
    endtask

    task automatic test_reset_mid();
        button_enter = 1'b1; step();
        button_enter = 1'b0; step(); step();
        n_cmp++; if (phase !== PH_WAIT) begin n_bad++; $display("FAIL mid_wait: got %0d want 2", phase); end
        reset = 1'b1; step();
        n_cmp++; if (phase !== PH_VIEW || stage_start !== 4'b0000 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: phase %0d start %b busy %b want 0 / 0000 / 0", phase, stage_start, busy);
        end
        reset = 1'b0; step();
        n_cmp++; if (phase !== PH_VIEW || stage_start !== 4'b0000) begin
            n_bad++; $display("FAIL post_reset: phase %0d start %b want 0 / 0000", phase, stage_start);
        end
    endtask

    task automatic test_timeout();
        int w;
        button_enter = 1'b1; switch = 1'b1; step();
        button_enter = 1'b0; step();
`ifdef SEQ_TIMEOUT_EN
        w = 0;
        for (int i = 0; i < 40 && phase == PH_WAIT; i++) begin w++; step(); end
        n_cmp++; if (w !== 10) begin n_bad++; $display("FAIL timeout_len: got %0d want 10", w); end
        n_cmp++; if (phase !== PH_ERROR || error !== 1'b1 || stage !== 2'd0) begin
            n_bad++; $display("FAIL timeout_err: phase %0d error %b stage %0d want 4 / 1 / 0", phase, error, stage);
        end
        button_enter = 1'b1; step();
        n_cmp++; if (stage_start !== 4'b0001 || error !== 1'b0) begin
            n_bad++; $display("FAIL retry: start %b error %b want 0001 / 0", stage_start, error);
        end
        button_enter = 1'b0;
`else
        w = 0;
        for (int i = 0; i < 15; i++) begin
            if (phase == PH_WAIT && error == 1'b0) w++;
            step();
        end
        n_cmp++; if (w !== 15 || phase !== PH_WAIT || error !== 1'b0) begin
            n_bad++; $display("FAIL no_timeout: waited %0d phase %0d error %b want 15 / 2 / 0", w, phase, error);
        end
`endif
        reset = 1'b1; step();
        reset = 1'b0; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_press_and_ignore();
        test_autochain();
        test_back();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
